// File: rtl/palette_rgb_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | palette_rgb_lut                                                            |
// | Run-time loadable palette: coded pixel index -> 24-bit RGB, with per-entry |
// | blink and blanking. Two-stage pipeline feeding the VGA DAC.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module palette_rgb_lut #(
  parameter int          IDX_W        = 2,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] BLINK_RGB    = 24'h000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] codedColor,
  input  logic             pix_valid_i,
  input  logic             blank_i,
  input  logic             frame_start_i,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [23:0]      wr_data,
  input  logic             wr_blink,
  output logic [23:0]      RGB,
  output logic             pix_valid_o,
  output logic             blink_phase_o
);

  localparam int          DEPTH    = 2 ** IDX_W;
  localparam logic [7:0]  CNT_LAST = 8'(BLINK_FRAMES - 1);

  logic [23:0]      pal [DEPTH];
  logic [DEPTH-1:0] blink;

  logic [IDX_W-1:0] s1_idx;
  logic             s1_valid;
  logic             s1_blank;

  logic [7:0]       frame_cnt;
  logic             blink_phase;
  logic [23:0]      rgb_next;

  function automatic logic [23:0] reset_color(input int i);
    case (i)
      0:       return 24'hF73800;
      1:       return 24'hFFA600;
      2:       return 24'hABFFFB;
      default: return 24'h000000;
    endcase
  endfunction

  // One register pair per entry; no read bypass, so a same-cycle read sees the old value.
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      logic [23:0] color;
      logic        blink_en;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          color    <= reset_color(g);
          blink_en <= 1'b0;
        end else if (wr_en && (wr_addr == IDX_W'(g))) begin
          color    <= wr_data;
          blink_en <= wr_blink;
        end
      end

      assign pal[g]   = color;
      assign blink[g] = blink_en;
    end
  endgenerate

  // Global blink timer: phase flips each time the frame count wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b1;
    end else if (frame_start_i) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rgb_next = pal[s1_idx];
    if (s1_blank || !s1_valid) begin
      rgb_next = 24'h000000;
    end else if (blink[s1_idx] && !blink_phase) begin
      rgb_next = BLINK_RGB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_idx      <= '0;
      s1_valid    <= 1'b0;
      s1_blank    <= 1'b0;
      RGB         <= 24'h000000;
      pix_valid_o <= 1'b0;
    end else begin
      s1_idx      <= codedColor;
      s1_valid    <= pix_valid_i;
      s1_blank    <= blank_i;
      RGB         <= rgb_next;
      pix_valid_o <= s1_valid;
    end
  end

  assign blink_phase_o = blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_palette_rgb_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_palette_rgb_lut                                                         |
// | Scoreboard bench for palette_rgb_lut (IDX_W=3, BLINK_FRAMES=2).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_palette_rgb_lut;

  localparam int IDX_W = 3;
  localparam int BF    = 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IDX_W-1:0] codedColor;
  logic             pix_valid_i, blank_i, frame_start_i;
  logic             wr_en, wr_blink;
  logic [IDX_W-1:0] wr_addr;
  logic [23:0]      wr_data;
  logic [23:0]      RGB;
  logic             pix_valid_o, blink_phase_o;

  always #5 clk = ~clk;

  palette_rgb_lut #(.IDX_W(IDX_W), .BLINK_FRAMES(BF), .BLINK_RGB(24'h000000)) dut (
    .clk(clk), .rst_n(rst_n), .codedColor(codedColor), .pix_valid_i(pix_valid_i),
    .blank_i(blank_i), .frame_start_i(frame_start_i), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_blink(wr_blink),
    .RGB(RGB), .pix_valid_o(pix_valid_o), .blink_phase_o(blink_phase_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [23:0]      m_pal   [DEPTH];
  logic             m_blink [DEPTH];
  int               m_cnt;
  logic             m_phase;
  logic [IDX_W-1:0] m_idx;
  logic             m_valid, m_blank;

  typedef struct {
    logic [23:0] rgb;
    logic        valid;
    logic        phase;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_pal[i]   = (i == 0) ? 24'hF73800 : (i == 1) ? 24'hFFA600 :
                   (i == 2) ? 24'hABFFFB : 24'h000000;
      m_blink[i] = 1'b0;
    end
    m_cnt = 0; m_phase = 1'b1;
    m_idx = '0; m_valid = 1'b0; m_blank = 1'b0;
  endtask

  // Called at a negedge: drives one cycle, predicts the result of the next edge, checks it.
  task automatic cycle(input logic [IDX_W-1:0] idx, input logic valid, input logic blank,
                       input logic fs, input logic we, input logic [IDX_W-1:0] waddr,
                       input logic [23:0] wdata, input logic wb);
    exp_t e;
    codedColor = idx; pix_valid_i = valid; blank_i = blank; frame_start_i = fs;
    wr_en = we; wr_addr = waddr; wr_data = wdata; wr_blink = wb;
    if (m_blank || !m_valid)           e.rgb = 24'h000000;
    else if (m_blink[m_idx] && !m_phase) e.rgb = 24'h000000;
    else                               e.rgb = m_pal[m_idx];
    e.valid = m_valid;
    if (fs) begin
      if (m_cnt == BF - 1) begin m_cnt = 0; m_phase = ~m_phase; end
      else m_cnt++;
    end
    e.phase = m_phase;
    sb.push_back(e);
    if (we) begin m_pal[waddr] = wdata; m_blink[waddr] = wb; end
    m_idx = idx; m_valid = valid; m_blank = blank;
    @(posedge clk); #1;
    e = sb.pop_front();
    check("rgb",   RGB,                 e.rgb);
    check("valid", 24'(pix_valid_o),    24'(e.valid));
    check("phase", 24'(blink_phase_o),  24'(e.phase));
    @(negedge clk);
  endtask

  task automatic px(input logic [IDX_W-1:0] idx);
    cycle(idx, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h0, 1'b0);
  endtask

  task automatic fpx(input logic [IDX_W-1:0] idx);
    cycle(idx, 1'b1, 1'b0, 1'b1, 1'b0, '0, 24'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    codedColor = '0; pix_valid_i = 0; blank_i = 0; frame_start_i = 0;
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_blink = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_rgb",   RGB, 24'h0);
    check("rst_valid", 24'(pix_valid_o), 24'h0);
    check("rst_phase", 24'(blink_phase_o), 24'h1);
    rst_n = 1'b1;

    // Reset palette contents, two-cycle latency
    px(3'd0); px(3'd1);
    check("t1_e0", RGB, 24'hF73800);
    px(3'd2);
    check("t1_e1", RGB, 24'hFFA600);
    px(3'd3);
    check("t1_e2", RGB, 24'hABFFFB);
    cycle('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 24'h0, 1'b0);
    check("t1_e3", RGB, 24'h000000);
    check("t1_e3v", 24'(pix_valid_o), 24'h1);
    cycle('0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 24'h0, 1'b0);

    // Write-while-read: old value in the write cycle, new one after
    px(3'd1);
    cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 24'h123456, 1'b0);
    check("t2_old", RGB, 24'hFFA600);
    px(3'd1);
    check("t2_new", RGB, 24'h123456);

    // Blink on entry 2
    cycle(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 24'hABFFFB, 1'b1);
    px(3'd2); px(3'd2);
    check("t3_on0", RGB, 24'hABFFFB);
    fpx(3'd2); px(3'd2);
    check("t3_p1", 24'(blink_phase_o), 24'h1);
    fpx(3'd2);
    check("t3_p2", 24'(blink_phase_o), 24'h0);
    px(3'd2);
    check("t3_off", RGB, 24'h000000);
    fpx(3'd2); px(3'd2);
    check("t3_off2", RGB, 24'h000000);
    fpx(3'd2);
    check("t3_p4", 24'(blink_phase_o), 24'h1);
    px(3'd2);
    check("t3_on1", RGB, 24'hABFFFB);

    // Blanking forces black without masking valid
    for (int i = 0; i < 3; i++) cycle(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 24'h0, 1'b0);
    check("t4_rgb", RGB, 24'h000000);
    check("t4_valid", 24'(pix_valid_o), 24'h1);

    // Reset mid-stream after a write
    cycle(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 24'h111111, 1'b1);
    px(3'd0); px(3'd0);
    check("t5_pre", RGB, 24'h111111);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rgb",   RGB, 24'h0);
    check("t5_valid", 24'(pix_valid_o), 24'h0);
    check("t5_phase", 24'(blink_phase_o), 24'h1);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    px(3'd0);
    check("t5_flush", 24'(pix_valid_o), 24'h0);
    px(3'd1);
    check("t5_e0", RGB, 24'hF73800);
    px(3'd5);
    check("t5_e1", RGB, 24'hFFA600);

    // Upper entries
    cycle(3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 24'hFFFFFF, 1'b0);
    check("t6_e5", RGB, 24'h000000);
    px(3'd7); px(3'd0);
    check("t6_e7", RGB, 24'hFFFFFF);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      cycle(IDX_W'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) == 0), IDX_W'($urandom_range(0, DEPTH - 1)),
            24'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
